// File: rtl/calc_pkg.sv
// Shared definitions for the BCD conversion engine: default sizes and FSM states.
package calc_pkg;

  localparam int unsigned DEF_B_SIZE = 32;
  localparam int unsigned DEF_DIGITS = 8;
  localparam int unsigned CNT_W      = $clog2(DEF_B_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit above 4, then shift left
// one place taking in bit_i. The bit pushed out of the top digit is carry_o.
module bcd_dabble_step
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic [DIGITS*4-1:0] acc_i,
  input  logic                bit_i,
  output logic [DIGITS*4-1:0] acc_o,
  output logic                carry_o
);

  logic [DIGITS*4-1:0] corr;

  // Per-digit add-3 correction followed by the one-bit shift.
  always_comb begin
    corr = acc_i;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_i[i*4 +: 4] > 4'd4) begin
        corr[i*4 +: 4] = acc_i[i*4 +: 4] + 4'd3;
      end
    end
    {carry_o, acc_o} = {corr, bit_i};
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shared sequential binary-to-BCD converter with a two-port round-robin
// arbiter. One shift-add-3 iteration per clock; result and overflow flag are
// returned to the granted requester with a one-cycle done pulse.
module bcd_convert_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned B_SIZE = DEF_B_SIZE,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [B_SIZE-1:0]   bin0,
  input  logic [B_SIZE-1:0]   bin1,
  output logic [1:0]          grant,
  output logic                busy,
  output logic [1:0]          done,
  output logic [DIGITS*4-1:0] bcd,
  output logic                ovf
);

  // Same formula as CNT_W, but tracks this instance's B_SIZE.
  localparam int unsigned CW = (B_SIZE > 1) ? $clog2(B_SIZE) : 1;

  state_e              state_q, state_d;
  logic [B_SIZE-1:0]   sh_q, sh_d;
  logic [DIGITS*4-1:0] acc_q, acc_d;
  logic                sticky_q, sticky_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;
  logic [1:0]          done_q, done_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  logic [DIGITS*4-1:0] step_acc;
  logic                step_carry;
  logic                sel;

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .acc_i   (acc_q),
    .bit_i   (sh_q[B_SIZE-1]),
    .acc_o   (step_acc),
    .carry_o (step_carry)
  );

  // State and datapath registers; last_q resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      grant_q  <= '0;
      last_q   <= 1'b1;
      done_q   <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  // Arbitration, iteration control and result capture.
  // The result is captured on the final SHIFT edge straight from the step
  // output so that bcd/ovf are already valid in the DONE cycle.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    done_d   = '0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    sel      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel      = (req == 2'b11) ? ~last_q : req[1];
          last_d   = sel;
          sh_d     = sel ? bin1 : bin0;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          grant_d  = sel ? 2'b10 : 2'b01;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        acc_d    = step_acc;
        sh_d     = sh_q << 1;
        sticky_d = sticky_q | step_carry;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(B_SIZE - 1)) begin
          bcd_d   = step_acc;
          ovf_d   = sticky_q | step_carry;
          done_d  = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;

endmodule
